// File: rtl/vga_pkg.sv
// Shared VGA timing definitions for the raster generator and the pixel sources.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int unsigned timing_total(vga_timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with synchronous active-low reset to a fixed value.
// Depth 0 degenerates to a wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned      Depth    = 1,
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [Width-1:0] stage_q [Depth];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    stage_q[i] <= ResetVal;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(Depth); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters, undelayed position flags and
// sync/blank strobes delayed to line up with the registered RGB of the pixel source.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned H_FP        = DefHFp,
    parameter int unsigned H_SYNC      = DefHSync,
    parameter int unsigned H_BP        = DefHBp,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned V_FP        = DefVFp,
    parameter int unsigned V_SYNC      = DefVSync,
    parameter int unsigned V_BP        = DefVBp,
    parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_LOW,
    parameter int unsigned PIX_LATENCY = 1,
    parameter int unsigned COUNT_W     = 10
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               clk_en,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n
);

    localparam vga_timing_t HTiming = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                        sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t VTiming = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                        sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int unsigned H_TOTAL = timing_total(HTiming);
    localparam int unsigned V_TOTAL = timing_total(VTiming);

    localparam logic [COUNT_W-1:0] HLast   = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] VLast   = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] HActEnd = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] VActEnd = COUNT_W'(V_ACTIVE);
    localparam logic [COUNT_W-1:0] HsFirst = COUNT_W'(H_ACTIVE + H_FP);
    localparam logic [COUNT_W-1:0] HsLast  = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COUNT_W-1:0] VsFirst = COUNT_W'(V_ACTIVE + V_FP);
    localparam logic [COUNT_W-1:0] VsLast  = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (((H_TOTAL - 1) >> COUNT_W) != 0 || ((V_TOTAL - 1) >> COUNT_W) != 0) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COUNT_W bits");
    end
    if (PIX_LATENCY > 4) begin : g_bad_latency
        $error("vga_timing_gen: PIX_LATENCY must be 0..4");
    end

    logic [COUNT_W-1:0] hcount_q, hcount_d;
    logic [COUNT_W-1:0] vcount_q, vcount_d;
    // Set by reset; the first enabled edge after release clears it without advancing, so
    // position 0/0 is presented for a full pixel before counting starts.
    logic               hold_q, hold_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hold_d   = hold_q;
        if (clk_en) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else if (hcount_q == HLast) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hold_q   <= 1'b1;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hold_q   <= hold_d;
        end
    end

    logic run;
    logic hs_on;
    logic vs_on;

    assign run   = ~hold_q;
    assign hs_on = run && (hcount_q >= HsFirst) && (hcount_q <= HsLast);
    assign vs_on = run && (vcount_q >= VsFirst) && (vcount_q <= VsLast);

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = run && (hcount_q < HActEnd) && (vcount_q < VActEnd);
    assign line_start  = run && (hcount_q == '0);
    assign frame_start = line_start && (vcount_q == '0);

    logic [2:0] pipe_in;
    logic [2:0] pipe_out;

    assign pipe_in = {hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                      vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                      active};

    vga_delay_line #(
        .Depth   (PIX_LATENCY),
        .Width   (3),
        .ResetVal({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0})
    ) u_delay (
        .clk_i (vga_clk),
        .rst_ni(reset_n),
        .en_i  (clk_en),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign vga_hs      = pipe_out[2];
    assign vga_vs      = pipe_out[1];
    assign vga_blank_n = pipe_out[0];
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance, a PIX_LATENCY=2 instance and a tiny
// active-high-sync instance used for whole-frame and mid-frame reset checks.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_en  = 1'b1;

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] hcount, vcount;
    logic       active, line_start, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    logic [9:0] hcount2, vcount2;
    logic       active2, line_start2, frame_start2, vga_hs2, vga_vs2, vga_blank_n2, vga_sync_n2;

    logic [4:0] hcount_s, vcount_s;
    logic       active_s, line_start_s, frame_start_s, vga_hs_s, vga_vs_s, vga_blank_n_s;
    logic       vga_sync_n_s;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .clk_en(clk_en),
        .hcount(hcount), .vcount(vcount), .active(active),
        .line_start(line_start), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
    );

    vga_timing_gen #(.PIX_LATENCY(2)) dut_lat2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .clk_en(clk_en),
        .hcount(hcount2), .vcount(vcount2), .active(active2),
        .line_start(line_start2), .frame_start(frame_start2),
        .vga_hs(vga_hs2), .vga_vs(vga_vs2), .vga_blank_n(vga_blank_n2),
        .vga_sync_n(vga_sync_n2)
    );

    // 16 x 10 raster: hsync at hcount 10..12, vsync on lines 7..8, active-high syncs.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(1'b1), .PIX_LATENCY(1), .COUNT_W(5)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n), .clk_en(clk_en),
        .hcount(hcount_s), .vcount(vcount_s), .active(active_s),
        .line_start(line_start_s), .frame_start(frame_start_s),
        .vga_hs(vga_hs_s), .vga_vs(vga_vs_s), .vga_blank_n(vga_blank_n_s),
        .vga_sync_n(vga_sync_n_s)
    );

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        int n = 0;
        while (!(hcount == h && vcount == v) && n < 2000) begin
            cyc();
            n++;
        end
        check(tag, 32'(hcount == h && vcount == v), 1);
    endtask

    task automatic run_to_s(input int h, input int v, input string tag);
        int n = 0;
        while (!(hcount_s == h && vcount_s == v) && n < 400) begin
            cyc();
            n++;
        end
        check(tag, 32'(hcount_s == h && vcount_s == v), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vs_cnt;

        reset_n = 1'b0;
        clk_en  = 1'b1;
        repeat (5) cyc();
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_blank_n", vga_blank_n, 0);
        check("rst_active", active, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_hcount", hcount, 0);
        check("rst_vcount", vcount, 0);
        check("rst_sync_n", vga_sync_n, 0);
        check("rst_hs_s", vga_hs_s, 0);
        check("rst_blank_n2", vga_blank_n2, 0);

        reset_n = 1'b1;
        cyc();
        check("rel_hcount", hcount, 0);
        check("rel_vcount", vcount, 0);
        check("rel_frame_start", frame_start, 1);
        check("rel_line_start", line_start, 1);
        check("rel_active", active, 1);
        check("rel_blank_n", vga_blank_n, 0);
        cyc();
        check("h1_hcount", hcount, 1);
        check("h1_frame_start", frame_start, 0);
        check("h1_blank_n", vga_blank_n, 1);
        check("h1_blank_n2", vga_blank_n2, 0);
        cyc();
        check("h2_blank_n2", vga_blank_n2, 1);

        run_to(641, 0, "reach_641");
        check("h641_active", active, 0);
        check("h641_blank_n", vga_blank_n, 0);
        check("h641_blank_n2", vga_blank_n2, 1);
        cyc();
        check("h642_blank_n2", vga_blank_n2, 0);

        run_to(656, 0, "reach_656");
        check("h656_hs", vga_hs, 1);
        cyc();
        check("h657_hs", vga_hs, 0);
        n = 0;
        while (vga_hs === 1'b0 && n < 200) begin
            n++;
            cyc();
        end
        check("hs_width", n, 96);
        check("hs_rise_hcount", hcount, 753);

        run_to(799, 0, "reach_799");
        cyc();
        check("wrap_hcount", hcount, 0);
        check("wrap_vcount", vcount, 1);
        check("wrap_line_start", line_start, 1);
        check("wrap_frame_start", frame_start, 0);
        n = 0;
        for (int i = 0; i < 800; i++) begin
            if (active === 1'b1) n++;
            cyc();
        end
        check("active_width", n, 640);

        run_to(639, 2, "reach_639");
        cyc();
        check("en_h640", hcount, 640);
        check("en_blank_640", vga_blank_n, 1);
        clk_en = 1'b0;
        cyc();
        check("en_hold1_hcount", hcount, 640);
        check("en_hold1_blank", vga_blank_n, 1);
        cyc();
        check("en_hold2_hcount", hcount, 640);
        check("en_hold2_blank", vga_blank_n, 1);
        check("en_hold2_blank2", vga_blank_n2, 1);
        clk_en = 1'b1;
        cyc();
        check("en_resume_hcount", hcount, 641);
        check("en_resume_blank", vga_blank_n, 0);
        check("en_resume_blank2", vga_blank_n2, 1);

        run_to_s(0, 0, "s_reach_frame");
        check("s_frame_start", frame_start_s, 1);
        n = 0;
        vs_cnt = 0;
        do begin
            if (vga_vs_s === 1'b1) vs_cnt++;
            cyc();
            n++;
        end while (frame_start_s !== 1'b1 && n < 400);
        check("s_frame_period", n, 160);
        check("s_vs_width", vs_cnt, 32);
        check("s_wrap_h", hcount_s, 0);
        check("s_wrap_v", vcount_s, 0);

        run_to_s(11, 7, "s_reach_sync");
        check("s_in_hs", vga_hs_s, 1);
        check("s_in_vs", vga_vs_s, 1);
        reset_n = 1'b0;
        clk_en  = 1'b0;
        cyc();
        check("mid_rst_hs_s", vga_hs_s, 0);
        check("mid_rst_vs_s", vga_vs_s, 0);
        check("mid_rst_blank_s", vga_blank_n_s, 0);
        check("mid_rst_hcount_s", hcount_s, 0);
        check("mid_rst_vcount_s", vcount_s, 0);
        check("mid_rst_hs", vga_hs, 1);
        check("mid_rst_vs", vga_vs, 1);
        check("mid_rst_hcount", hcount, 0);
        clk_en = 1'b1;
        cyc();
        reset_n = 1'b1;
        cyc();
        check("mid_rel_hcount_s", hcount_s, 0);
        check("mid_rel_vcount_s", vcount_s, 0);
        check("mid_rel_active_s", active_s, 1);
        check("mid_rel_frame_start_s", frame_start_s, 1);
        cyc();
        check("mid_rel_h1_s", hcount_s, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing for the display path. It drives the free-running hcount/vcount pixel coordinates consumed by the pixel sources, such as the test pattern and chess board renderers. It also drives the hsync, vsync, blank and sync strobes to the DAC/connector. Sync and blank outputs are delayed by a parameterised pipeline so they align with the registered RGB produced by the pixel source.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 1'b0, asserted level of vga_hs/vga_vs (0 = active-low)
PIX_LATENCY, 1, cycles of delay from hcount/vcount to pixel-source RGB output (0..4)
COUNT_W, 10, width of hcount/vcount

Ports:
vga_clk  in  1  pixel clock, 25 MHz nominal
reset_n  in  1  synchronous active-low reset, sampled on rising vga_clk
clk_en  in  1  pixel advance enable; tie high at 25 MHz
hcount  out  COUNT_W  current horizontal pixel position, 0..H_TOTAL-1
vcount  out  COUNT_W  current line position, 0..V_TOTAL-1
active  out  1  hcount<H_ACTIVE && vcount<V_ACTIVE, aligned with the counters (undelayed)
line_start  out  1  one-cycle pulse when hcount==0, undelayed
frame_start  out  1  one-cycle pulse when hcount==0 && vcount==0, undelayed
vga_hs  out  1  horizontal sync, delayed PIX_LATENCY
vga_vs  out  1  vertical sync, delayed PIX_LATENCY
vga_blank_n  out  1  high during the visible region, delayed PIX_LATENCY
vga_sync_n  out  1  DAC composite sync, constant 0 after reset

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Clock and reset: one clock, vga_clk. reset_n is synchronous and active-low. No asynchronous reset path.
- Reset (reset_n low at a clock edge): on the next cycle hcount=0, vcount=0, active=0, line_start=0, frame_start=0, vga_hs=vga_vs=~SYNC_ACTIVE, vga_blank_n=0, vga_sync_n=0. Every delay-line stage is flushed to these inactive values.
- First cycle after reset release: counters read 0/0, so active=1 and frame_start=line_start=1 combinationally from the counters.
- Counters advance only on edges where clk_en=1. All outputs and pipeline stages hold while clk_en=0.
- Horizontal counter: increments each enabled cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the hcount wrap. When vcount==V_TOTAL-1 coincides with the hcount wrap, vcount wraps to 0.
- Undelayed flags (active, line_start, frame_start): combinational decodes of the registered counters. The counters themselves are registered, so these flags are glitch-free.
- hsync window: asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 at defaults.
- vsync window: asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, over whole lines (hcount 0..799).
- Delay line:
  - hs, vs and blank_n pass through a PIX_LATENCY-deep register chain. Each stage advances only on clk_en.
  - PIX_LATENCY=0 means the outputs are combinational from the counters.
  - Result: vga_blank_n rises exactly PIX_LATENCY enabled cycles after active rises.
- Width rule: elaboration-time assertion that H_TOTAL and V_TOTAL fit in COUNT_W bits, and that PIX_LATENCY<=4.
- Reset mid-frame: counters return to 0/0 regardless of position, and sync outputs deassert immediately on the next edge, even inside a sync pulse.
- Reset and clk_en together: reset takes priority over clk_en=0.
- Frame: 420000 enabled cycles at defaults (59.52 Hz at 25 MHz).

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants (H_ACTIVE..V_BP);
  - a timing struct type {active, fp, sync, bp};
  - localparams for SYNC_ACTIVE_LOW/HIGH.
- The pixel source modules share the same package.
- One sub-module is natural: vga_delay_line. It is a parameterised-depth, parameterised-width shift register with enable, synchronous active-low reset and a parameterised reset value. It carries {hs, vs, blank_n}.

Test Plan:
- Reset hold 5 cycles then release -> during reset vga_hs=vga_vs=1, vga_blank_n=0; first post-reset cycle hcount=0, vcount=0, frame_start=1, line_start=1, active=1.
- Run one line at vcount=0 -> hcount 799 wraps to 0 and vcount becomes 1; vga_hs low for exactly 96 cycles, falling when the delayed position reaches hcount=656 (one cycle after 656 with PIX_LATENCY=1); active high for 640 cycles.
- Run a full frame -> vga_vs low for exactly 1600 cycles (lines 490-491); after vcount=524/hcount=799, counters read 0/0 with frame_start=1; frame_start period is 420000 cycles.
- PIX_LATENCY=2 build -> vga_blank_n rises 2 cycles after active rises at hcount=0, vcount=10, and falls 2 cycles after hcount reaches 640.
- clk_en toggled 1,0,0,1 at hcount=100 -> hcount sequence 100,101,101,101,102; delayed outputs hold.
- Assert reset_n at hcount=700, vcount=490 (inside hsync and vsync) -> next cycle vga_hs=vga_vs=1, vga_blank_n=0; counters 0/0 after release.
